// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: redirect inputs, I-cache request/response and decode handshake.
interface fetch_if #(
    parameter int unsigned ADDR_SIZE  = 32,
    parameter int unsigned INSTR_SIZE = 32
);
    logic                  is_exception;
    logic                  is_jump;
    logic                  is_branch;
    logic [ADDR_SIZE-1:0]  pc_jump;
    logic [ADDR_SIZE-1:0]  pc_branch;
    logic                  icache_req;
    logic [ADDR_SIZE-1:0]  icache_addr;
    logic                  icache_hit;
    logic [INSTR_SIZE-1:0] icache_data;
    logic                  dec_valid;
    logic [INSTR_SIZE-1:0] dec_instr;
    logic [ADDR_SIZE-1:0]  dec_pc;
    logic                  dec_ready;

    modport master (
        input  is_exception, is_jump, is_branch, pc_jump, pc_branch,
        output icache_req, icache_addr,
        input  icache_hit, icache_data,
        output dec_valid, dec_instr, dec_pc,
        input  dec_ready
    );

    modport slave (
        output is_exception, is_jump, is_branch, pc_jump, pc_branch,
        input  icache_req, icache_addr,
        output icache_hit, icache_data,
        input  dec_valid, dec_instr, dec_pc,
        output dec_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC selection, I-cache request/miss stall, {pc,instr} FIFO to decode.
// Optional performance counters enabled by defining FETCH_PERF_EN.
module fetch_unit #(
    parameter int unsigned           ADDR_SIZE   = 32,
    parameter int unsigned           INSTR_SIZE  = 32,
    parameter int unsigned           QUEUE_DEPTH = 4,
    parameter logic [ADDR_SIZE-1:0]  RESET_PC    = ADDR_SIZE'('h00001000),
    parameter logic [ADDR_SIZE-1:0]  EXC_VECTOR  = ADDR_SIZE'('h00002000),
    parameter int unsigned           PC_STEP     = 4
) (
    input  logic       clk,
    input  logic       reset,
    fetch_if.master    bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_miss_cyc,
    output logic [31:0] perf_redirect
`endif
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MISS, S_FULL} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0]   mem_pc_q    [QUEUE_DEPTH];
    logic [INSTR_SIZE-1:0]  mem_instr_q [QUEUE_DEPTH];

    logic                   redirect_c;
    logic [ADDR_SIZE-1:0]   target_c;
    logic                   req_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   full_c;

    // Redirect target, exception > jump > branch
    always_comb begin
        redirect_c = bus.is_exception | bus.is_jump | bus.is_branch;
        target_c   = bus.pc_branch;
        if (bus.is_exception)   target_c = EXC_VECTOR;
        else if (bus.is_jump)   target_c = bus.pc_jump;
    end

    // Full check looks at the registered count only
    assign full_c = (count_q == CNT_W'(QUEUE_DEPTH));
    assign push_c = req_c & bus.icache_hit & ~redirect_c;
    assign pop_c  = (count_q != '0) & bus.dec_ready & ~redirect_c;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                if (redirect_c)                 state_d = S_RUN;
                else if (full_c && !pop_c)      state_d = S_FULL;
                else if (req_c && !bus.icache_hit) state_d = S_MISS;
            end
            S_MISS: if (redirect_c || bus.icache_hit) state_d = S_RUN;
            S_FULL: if (redirect_c || pop_c)          state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_c = 1'b0;
        if ((state_q == S_RUN || state_q == S_MISS) && !full_c) req_c = 1'b1;
    end

    // PC and FIFO bookkeeping; a redirect flushes and drops the same-cycle hit/pop
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_c) begin
            pc_d     = target_c;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push_c) begin
                pc_d     = pc_q + ADDR_SIZE'(PC_STEP);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // FIFO storage needs no reset; validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (!reset && push_c) begin
            mem_pc_q[wr_ptr_q]    <= pc_q;
            mem_instr_q[wr_ptr_q] <= bus.icache_data;
        end
    end

    assign bus.icache_req  = req_c;
    assign bus.icache_addr = pc_q;
    assign bus.dec_valid   = (count_q != '0);
    assign bus.dec_pc      = mem_pc_q[rd_ptr_q];
    assign bus.dec_instr   = mem_instr_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_miss_cyc_q, perf_redirect_q;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q  <= '0;
            perf_miss_cyc_q <= '0;
            perf_redirect_q <= '0;
        end else begin
            if (push_c && perf_fetched_q != '1)              perf_fetched_q  <= perf_fetched_q + 32'd1;
            if (state_q == S_MISS && perf_miss_cyc_q != '1)  perf_miss_cyc_q <= perf_miss_cyc_q + 32'd1;
            if (redirect_c && perf_redirect_q != '1)         perf_redirect_q <= perf_redirect_q + 32'd1;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_miss_cyc = perf_miss_cyc_q;
    assign perf_redirect = perf_redirect_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: streaming, backpressure, miss, redirects, wrap, reset.
module tb_fetch_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_if #(.ADDR_SIZE(32), .INSTR_SIZE(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_miss_cyc, perf_redirect;
`endif

    fetch_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_miss_cyc (perf_miss_cyc),
        .perf_redirect (perf_redirect)
`endif
    );

    // Cache returns a value derived from the address so each instruction is traceable
    assign bus.icache_data = bus.icache_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.is_exception = 1'b0;
        bus.is_jump      = 1'b0;
        bus.is_branch    = 1'b0;
        bus.pc_jump      = '0;
        bus.pc_branch    = '0;
        bus.icache_hit   = 1'b0;
        bus.dec_ready    = 1'b0;
    endtask

    // Leaves the DUT in RUN with pc=0x1000 and an empty FIFO
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        chk("rst_req",   64'(bus.icache_req),  64'h0);
        chk("rst_valid", 64'(bus.dec_valid),   64'h0);
        chk("rst_addr",  64'(bus.icache_addr), 64'h1000);

        // 1: streaming at one instruction per cycle
        reset = 1'b0;
        bus.icache_hit = 1'b1;
        bus.dec_ready  = 1'b1;
        step();
        chk("t1_req",   64'(bus.icache_req),  64'h1);
        chk("t1_addr0", 64'(bus.icache_addr), 64'h1000);
        chk("t1_v0",    64'(bus.dec_valid),   64'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_addr",  64'(bus.icache_addr), 64'(32'h1004 + 32'(4 * i)));
            chk("t1_valid", 64'(bus.dec_valid),   64'h1);
            chk("t1_dpc",   64'(bus.dec_pc),      64'(32'h1000 + 32'(4 * i)));
            chk("t1_instr", 64'(bus.dec_instr),   64'((32'h1000 + 32'(4 * i)) ^ 32'hA5A5_0000));
        end

        // 2: backpressure fills the FIFO, then drains in order
        do_reset();
        bus.icache_hit = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t2_req_full", 64'(bus.icache_req),  64'h0);
        chk("t2_addr",     64'(bus.icache_addr), 64'h1010);
        chk("t2_dpc_hold", 64'(bus.dec_pc),      64'h1000);
        step();
        chk("t2_req_fullst", 64'(bus.icache_req), 64'h0);
        chk("t2_dpc_hold2",  64'(bus.dec_pc),     64'h1000);
        bus.dec_ready = 1'b1;
        step();
        chk("t2_req_back", 64'(bus.icache_req), 64'h1);
        chk("t2_dpc_pop",  64'(bus.dec_pc),     64'h1004);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t2_dpc_seq",   64'(bus.dec_pc),    64'(32'h1004 + 32'(4 * k)));
            chk("t2_instr_seq", 64'(bus.dec_instr), 64'((32'h1004 + 32'(4 * k)) ^ 32'hA5A5_0000));
        end

        // 3: miss stall at 0x1008
        do_reset();
        bus.icache_hit = 1'b1;
        bus.dec_ready  = 1'b1;
        step();
        step();
        chk("t3_addr_pre", 64'(bus.icache_addr), 64'h1008);
        bus.icache_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_addr_hold", 64'(bus.icache_addr), 64'h1008);
            chk("t3_req_hold",  64'(bus.icache_req),  64'h1);
            chk("t3_nopush",    64'(bus.dec_valid),   64'h0);
        end
        bus.icache_hit = 1'b1;
        step();
        chk("t3_valid", 64'(bus.dec_valid),   64'h1);
        chk("t3_dpc",   64'(bus.dec_pc),      64'h1008);
        chk("t3_addr",  64'(bus.icache_addr), 64'h100C);

        // 4: branch with 3 queued entries flushes and drops the same-cycle hit
        do_reset();
        bus.icache_hit = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t4_pre_valid", 64'(bus.dec_valid), 64'h1);
        bus.is_branch = 1'b1;
        bus.pc_branch = 32'h4000;
        step();
        chk("t4_flush", 64'(bus.dec_valid),   64'h0);
        chk("t4_addr",  64'(bus.icache_addr), 64'h4000);
        chk("t4_req",   64'(bus.icache_req),  64'h1);
        bus.is_branch = 1'b0;
        bus.dec_ready = 1'b1;
        step();
        chk("t4_dpc",   64'(bus.dec_pc),      64'h4000);
        chk("t4_valid", 64'(bus.dec_valid),   64'h1);
        chk("t4_addr2", 64'(bus.icache_addr), 64'h4004);

        // 5: redirect priority
        bus.is_exception = 1'b1;
        bus.is_jump      = 1'b1;
        bus.pc_jump      = 32'h3000;
        bus.is_branch    = 1'b1;
        bus.pc_branch    = 32'h4000;
        step();
        chk("t5_exc",   64'(bus.icache_addr), 64'h2000);
        chk("t5_flush", 64'(bus.dec_valid),   64'h0);
        bus.is_exception = 1'b0;
        step();
        chk("t5_jump", 64'(bus.icache_addr), 64'h3000);
        bus.is_jump   = 1'b0;
        bus.is_branch = 1'b0;
        step();
        chk("t5_dpc", 64'(bus.dec_pc), 64'h3000);

        // 6: PC wrap, then reset during a miss
        bus.is_jump = 1'b1;
        bus.pc_jump = 32'hFFFF_FFFC;
        step();
        chk("t6_top", 64'(bus.icache_addr), 64'hFFFF_FFFC);
        bus.is_jump = 1'b0;
        step();
        chk("t6_wrap",    64'(bus.icache_addr), 64'h0);
        chk("t6_dpc_top", 64'(bus.dec_pc),      64'hFFFF_FFFC);
        bus.icache_hit = 1'b0;
        step();
        chk("t6_miss_addr", 64'(bus.icache_addr), 64'h0);
        reset = 1'b1;
        step();
        chk("t6_rst_addr",  64'(bus.icache_addr), 64'h1000);
        chk("t6_rst_req",   64'(bus.icache_req),  64'h0);
        chk("t6_rst_valid", 64'(bus.dec_valid),   64'h0);
        reset = 1'b0;
        step();
        chk("t6_run_req", 64'(bus.icache_req), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
